lc3_datapath_gen: RTL and testbench

Parametrised next-generation LC-3 datapath. Keeps the single shared data bus, PC/MAR/MDR/IR registers, 8-entry register file, ALU, address adder, NZP condition codes and BEN logic, all generalised to `WIDTH` bits. It replaces the fixed-timing memory-select path with a request/acknowledge memory sequencer that has a timeout. It also adds bus-conflict detection. It sits between the control FSM and the memory/IO subsystem.

---
 rtl/lc3_gen_pkg.sv | 34 +++
 rtl/mem_sequencer.sv | 71 +++++++
 rtl/lc3_datapath_gen.sv | 172 +++++++++++++++++
 tb/tb_lc3_datapath_gen.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_gen_pkg.sv
// Shared types, mux encodings and helpers for the generalised LC-3 datapath.
package lc3_gen_pkg;

    typedef enum logic {MEM_IDLE, MEM_REQ} mem_state_t;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_ADDER = 2'b01;
    localparam logic [1:0] PCMUX_BUS   = 2'b10;
    localparam logic [1:0] PCMUX_ZERO  = 2'b11;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    // Lower value wins when several gates drive the bus in the same cycle.
    localparam logic [1:0] BUS_PRI_PC     = 2'd0;
    localparam logic [1:0] BUS_PRI_MARMUX = 2'd1;
    localparam logic [1:0] BUS_PRI_MDR    = 2'd2;
    localparam logic [1:0] BUS_PRI_ALU    = 2'd3;

    // Sign-extend the low 'bits' bits of an instruction word to 16 bits.
    function automatic logic [15:0] sext(input logic [15:0] value, input logic [4:0] bits);
        logic [4:0] sh;
        sh = 5'd16 - bits;
        return 16'($signed(value << sh) >>> sh);
    endfunction

endpackage

// File: rtl/mem_sequencer.sv
// Request/acknowledge memory sequencer with a cycle-bounded timeout.
module mem_sequencer
    import lc3_gen_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_strobe,
    input  logic             wr_strobe,
    input  logic [WIDTH-1:0] mar,
    input  logic [WIDTH-1:0] mdr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_timeout,
    output logic             mdr_load,
    output logic [WIDTH-1:0] mdr_data
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

    mem_state_t  state;
    logic [15:0] count;
    logic        expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MEM_IDLE;
            count       <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    // Simultaneous read and write strobes are a control error and are dropped.
                    if (rd_strobe ^ wr_strobe) begin
                        mem_addr  <= mar;
                        mem_wdata <= mdr;
                        mem_we    <= wr_strobe;
                        count     <= '0;
                        state     <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (mem_ack) begin
                        state <= MEM_IDLE;
                    end else if (expired) begin
                        mem_timeout <= 1'b1;
                        state       <= MEM_IDLE;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

    assign mem_req  = (state == MEM_REQ);
    assign expired  = (count == LAST_COUNT);
    assign mdr_load = mem_req && !mem_we && (mem_ack || expired);
    assign mdr_data = mem_ack ? mem_rdata : '1;

endmodule

// File: rtl/lc3_datapath_gen.sv
// Generalised LC-3 datapath: shared bus, register file, ALU, address adder,
// condition codes, BEN and a request/acknowledge memory sequencer.
module lc3_datapath_gen
    import lc3_gen_pkg::*;
#(
    parameter int          WIDTH    = 16,
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int          TIMEOUT  = 255
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LD_PC,
    input  logic             LD_MAR,
    input  logic             LD_MDR,
    input  logic             LD_IR,
    input  logic             LD_REG,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic             GatePC,
    input  logic             GateMARMUX,
    input  logic             GateALU,
    input  logic             GateMDR,
    input  logic             DRMUX,
    input  logic             SR1MUX,
    input  logic             SR2MUX,
    input  logic             ADDR1MUX,
    input  logic [1:0]       PCMUX,
    input  logic [1:0]       ALUK,
    input  logic [1:0]       ADDR2MUX,
    input  logic             MEM_RD,
    input  logic             MEM_WR,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             mem_busy,
    output logic             mem_timeout,
    output logic             bus_conflict,
    output logic             BEN,
    output logic [WIDTH-1:0] IR_out,
    output logic [WIDTH-1:0] MAR_out,
    output logic [WIDTH-1:0] MDR_out,
    output logic [WIDTH-1:0] PC_out
);

    logic [WIDTH-1:0] pc, mar, mdr, ir, bus;
    logic [WIDTH-1:0] regfile [8];
    logic [2:0]       nzp, sr1_idx, dr_idx;
    logic [WIDTH-1:0] imm5, off6, off9, off11;
    logic [WIDTH-1:0] sr1_val, sr2_val, alu_out, addr1_val, addr2_val, adder_out, pc_next;
    logic [3:0]       gates;
    logic [WIDTH-1:0] bus_src [4];
    logic             seq_mdr_load;
    logic [WIDTH-1:0] seq_mdr_data;

    assign imm5  = WIDTH'($signed(sext(ir[15:0], 5'd5)));
    assign off6  = WIDTH'($signed(sext(ir[15:0], 5'd6)));
    assign off9  = WIDTH'($signed(sext(ir[15:0], 5'd9)));
    assign off11 = WIDTH'($signed(sext(ir[15:0], 5'd11)));

    assign sr1_idx   = SR1MUX ? ir[11:9] : ir[8:6];
    assign dr_idx    = DRMUX ? 3'd7 : ir[11:9];
    assign sr1_val   = regfile[sr1_idx];
    assign sr2_val   = SR2MUX ? imm5 : regfile[ir[2:0]];
    assign addr1_val = ADDR1MUX ? sr1_val : pc;
    assign adder_out = addr1_val + addr2_val;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        addr2_val = '0;
        case (ADDR2MUX)
            ADDR2_OFF6:  addr2_val = off6;
            ADDR2_OFF9:  addr2_val = off9;
            ADDR2_OFF11: addr2_val = off11;
            default:     addr2_val = '0;
        endcase
    end

    always_comb begin
        alu_out = sr1_val;
        case (ALUK)
            ALUK_ADD: alu_out = sr1_val + sr2_val;
            ALUK_AND: alu_out = sr1_val & sr2_val;
            ALUK_NOT: alu_out = ~sr1_val;
            default:  alu_out = sr1_val;
        endcase
    end

    always_comb begin
        pc_next = pc + 1'b1;
        case (PCMUX)
            PCMUX_ADDER: pc_next = adder_out;
            PCMUX_BUS:   pc_next = bus;
            PCMUX_ZERO:  pc_next = '0;
            default:     pc_next = pc + 1'b1;
        endcase
    end

    always_comb begin
        gates                  = '0;
        gates[BUS_PRI_PC]      = GatePC;
        gates[BUS_PRI_MARMUX]  = GateMARMUX;
        gates[BUS_PRI_MDR]     = GateMDR;
        gates[BUS_PRI_ALU]     = GateALU;
        bus_src[BUS_PRI_PC]     = pc;
        bus_src[BUS_PRI_MARMUX] = adder_out;
        bus_src[BUS_PRI_MDR]    = mdr;
        bus_src[BUS_PRI_ALU]    = alu_out;
        bus = '0;
        // Scan from lowest to highest priority so the highest-priority gate is applied last.
        for (int i = 3; i >= 0; i--) begin
            if (gates[i]) bus = bus_src[i];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc           <= WIDTH'(RESET_PC);
            mar          <= '0;
            mdr          <= '0;
            ir           <= '0;
            nzp          <= '0;
            BEN          <= 1'b0;
            bus_conflict <= 1'b0;
        end else begin
            if (LD_PC)  pc  <= pc_next;
            if (LD_MAR) mar <= bus;
            if (LD_IR)  ir  <= bus;
            if (seq_mdr_load) mdr <= seq_mdr_data;
            else if (LD_MDR)  mdr <= bus;
            if (LD_CC)  nzp <= {bus[WIDTH-1], bus == '0, !bus[WIDTH-1] && (bus != '0)};
            if (LD_BEN) BEN <= |(ir[11:9] & nzp);
            bus_conflict <= ($countones(gates) > 1);
        end
    end

    // NOTE: the register file is reset like every other architectural register, so software sees known contents.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 8; i++) regfile[i] <= '0;
        end else if (LD_REG) begin
            regfile[dr_idx] <= bus;
        end
    end

    mem_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_mem_sequencer (
        .clk        (Clk),
        .rst_n      (Reset),
        .rd_strobe  (MEM_RD),
        .wr_strobe  (MEM_WR),
        .mar        (mar),
        .mdr        (mdr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_timeout(mem_timeout),
        .mdr_load   (seq_mdr_load),
        .mdr_data   (seq_mdr_data)
    );

    assign mem_busy = mem_req;
    assign IR_out   = ir;
    assign MAR_out  = mar;
    assign MDR_out  = mdr;
    assign PC_out   = pc;

endmodule

// File: tb/tb_lc3_datapath_gen.sv
// Scoreboard bench for lc3_datapath_gen (WIDTH=32, TIMEOUT=4) with a behavioural datapath model.
module tb_lc3_datapath_gen;

    localparam int W = 32;
    localparam int T = 4;

    typedef struct packed {
        logic ld_pc, ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc, ld_ben;
        logic gate_pc, gate_marmux, gate_alu, gate_mdr;
        logic drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] pcmux, aluk, addr2mux;
    } ctrl_t;

    typedef struct {
        logic [W-1:0] addr;
        logic         we;
        logic [W-1:0] wdata;
        int           len;
        logic [W-1:0] mdr;
        logic         to;
    } exp_t;

    logic Clk = 1'b0, Reset;
    logic LD_PC, LD_MAR, LD_MDR, LD_IR, LD_REG, LD_CC, LD_BEN;
    logic GatePC, GateMARMUX, GateALU, GateMDR;
    logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] PCMUX, ALUK, ADDR2MUX;
    logic MEM_RD, MEM_WR;
    logic mem_req, mem_we, mem_ack, mem_busy, mem_timeout, bus_conflict, BEN;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata, IR_out, MAR_out, MDR_out, PC_out;

    lc3_datapath_gen #(.WIDTH(W), .RESET_PC(16'h3000), .TIMEOUT(T)) dut (
        .Clk(Clk), .Reset(Reset),
        .LD_PC(LD_PC), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR),
        .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
        .GatePC(GatePC), .GateMARMUX(GateMARMUX), .GateALU(GateALU), .GateMDR(GateMDR),
        .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .PCMUX(PCMUX), .ALUK(ALUK), .ADDR2MUX(ADDR2MUX),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_busy(mem_busy),
        .mem_timeout(mem_timeout), .bus_conflict(bus_conflict), .BEN(BEN),
        .IR_out(IR_out), .MAR_out(MAR_out), .MDR_out(MDR_out), .PC_out(PC_out)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int cur_lat = 0;
    logic [W-1:0] cur_rdata = '0;
    exp_t exp_q[$];

    // Reference model state
    logic [W-1:0] m_pc, m_mar, m_mdr, m_ir;
    logic [W-1:0] m_rf [8];
    logic [2:0]   m_nzp;
    logic         m_ben, m_to, m_conflict;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sx(input logic [15:0] v, input int n);
        longint x;
        x = longint'(v) & ((longint'(1) << n) - 1);
        if (x >= (longint'(1) << (n - 1))) x -= (longint'(1) << n);
        return W'(x);
    endfunction

    task automatic model_reset();
        m_pc = 32'h3000; m_mar = '0; m_mdr = '0; m_ir = '0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_nzp = '0; m_ben = 0; m_to = 0; m_conflict = 0;
    endtask

    task automatic drive(input ctrl_t c);
        LD_PC = c.ld_pc; LD_MAR = c.ld_mar; LD_MDR = c.ld_mdr; LD_IR = c.ld_ir;
        LD_REG = c.ld_reg; LD_CC = c.ld_cc; LD_BEN = c.ld_ben;
        GatePC = c.gate_pc; GateMARMUX = c.gate_marmux; GateALU = c.gate_alu; GateMDR = c.gate_mdr;
        DRMUX = c.drmux; SR1MUX = c.sr1mux; SR2MUX = c.sr2mux; ADDR1MUX = c.addr1mux;
        PCMUX = c.pcmux; ALUK = c.aluk; ADDR2MUX = c.addr2mux;
    endtask

    task automatic check_all(input string name);
        check({name, "_pc"}, PC_out, m_pc);
        check({name, "_mar"}, MAR_out, m_mar);
        check({name, "_mdr"}, MDR_out, m_mdr);
        check({name, "_ir"}, IR_out, m_ir);
        check({name, "_ben"}, W'(BEN), W'(m_ben));
        check({name, "_conflict"}, W'(bus_conflict), W'(m_conflict));
    endtask

    // One datapath cycle: the model computes the cycle from the spec rules, the DUT is driven, then compared.
    task automatic dp_op(input ctrl_t c, input string name);
        logic [W-1:0] a, b, alu, adder, off, bus, npc;
        logic [2:0] dr, nzp_new;
        int ngates;
        a = m_rf[c.sr1mux ? m_ir[11:9] : m_ir[8:6]];
        b = c.sr2mux ? sx(m_ir[15:0], 5) : m_rf[m_ir[2:0]];
        case (c.aluk)
            2'd0: alu = a + b;
            2'd1: alu = a & b;
            2'd2: alu = ~a;
            default: alu = a;
        endcase
        case (c.addr2mux)
            2'd0: off = '0;
            2'd1: off = sx(m_ir[15:0], 6);
            2'd2: off = sx(m_ir[15:0], 9);
            default: off = sx(m_ir[15:0], 11);
        endcase
        adder = (c.addr1mux ? a : m_pc) + off;
        if (c.gate_pc) bus = m_pc;
        else if (c.gate_marmux) bus = adder;
        else if (c.gate_mdr) bus = m_mdr;
        else if (c.gate_alu) bus = alu;
        else bus = '0;
        ngates = int'(c.gate_pc) + int'(c.gate_marmux) + int'(c.gate_mdr) + int'(c.gate_alu);
        case (c.pcmux)
            2'd0: npc = m_pc + 1;
            2'd1: npc = adder;
            2'd2: npc = bus;
            default: npc = '0;
        endcase
        dr = c.drmux ? 3'd7 : m_ir[11:9];
        nzp_new = {bus[W-1], bus == '0, !bus[W-1] && bus != '0};

        drive(c);
        @(negedge Clk);
        drive('0);

        if (c.ld_ben) m_ben = |(m_ir[11:9] & m_nzp);
        if (c.ld_pc) m_pc = npc;
        if (c.ld_mar) m_mar = bus;
        if (c.ld_mdr) m_mdr = bus;
        if (c.ld_ir) m_ir = bus;
        if (c.ld_reg) m_rf[dr] = bus;
        if (c.ld_cc) m_nzp = nzp_new;
        m_conflict = (ngates > 1);
        check_all(name);
    endtask

    task automatic mem_access(input logic rd, input int lat, input logic [W-1:0] rdata, input bit extra);
        exp_t e;
        int d;
        bit acked;
        acked = (lat >= 1 && lat <= T);
        e.addr = m_mar; e.we = !rd; e.wdata = m_mdr;
        e.len = acked ? lat : T;
        if (rd) m_mdr = acked ? rdata : '1;
        if (!acked) m_to = 1'b1;
        e.mdr = m_mdr; e.to = m_to;
        exp_q.push_back(e);
        cur_lat = lat; cur_rdata = rdata;
        d = done_cnt;
        if (rd) MEM_RD = 1'b1; else MEM_WR = 1'b1;
        @(negedge Clk);
        MEM_RD = 1'b0; MEM_WR = 1'b0;
        if (extra) begin
            MEM_RD = 1'b1;
            @(negedge Clk);
            MEM_RD = 1'b0;
        end
        for (int i = 0; i < 20 && done_cnt == d; i++) @(negedge Clk);
        check("mem_complete", W'(done_cnt != d), 1);
        m_conflict = 1'b0;
    endtask

    task automatic load_ir(input logic [W-1:0] v);
        ctrl_t c;
        mem_access(1'b1, 1, v, 1'b0);
        c = '0; c.gate_mdr = 1; c.ld_ir = 1;
        dp_op(c, "ld_ir");
    endtask

    // Memory responder: acks in cycle cur_lat of a request, otherwise offers junk data.
    initial begin
        int rcyc;
        rcyc = 0; mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge Clk);
            if (mem_req && Reset) begin
                rcyc++;
                mem_ack = (rcyc == cur_lat);
                mem_rdata = (rcyc == cur_lat) ? cur_rdata : W'($urandom);
            end else begin
                rcyc = 0;
                mem_ack = 1'b0;
            end
        end
    end

    // Monitor: pops the expected access at request start, checks the completion when mem_req drops.
    initial begin
        logic prev, active;
        int len;
        exp_t e;
        prev = 0; active = 0; len = 0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                prev = 0; active = 0;
            end else begin
                if (mem_req && !prev) begin
                    len = 1;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req: got request at addr %h expected none", mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        active = 1;
                        check("req_addr", mem_addr, e.addr);
                        check("req_we", W'(mem_we), W'(e.we));
                        check("req_wdata", mem_wdata, e.wdata);
                        check("req_busy", W'(mem_busy), 1);
                    end
                end else if (mem_req) begin
                    len++;
                end else if (prev && active) begin
                    check("req_len", W'(len), W'(e.len));
                    check("done_mdr", MDR_out, e.mdr);
                    check("done_timeout", W'(mem_timeout), W'(e.to));
                    active = 0;
                    done_cnt++;
                end
                prev = mem_req;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        ctrl_t c;
        exp_t e;
        Reset = 1'b0; MEM_RD = 0; MEM_WR = 0;
        drive('0);
        model_reset();
        repeat (2) @(negedge Clk);
        check("rst_pc_in_reset", PC_out, 32'h3000);
        check("rst_req_in_reset", W'(mem_req), 0);
        Reset = 1'b1;
        @(negedge Clk);
        check_all("reset");
        check("reset_req", W'(mem_req), 0);
        check("reset_timeout", W'(mem_timeout), 0);

        // Read at 0x3000 with ack in cycle 3
        c = '0; c.gate_pc = 1; c.ld_mar = 1;
        dp_op(c, "mar_pc");
        mem_access(1'b1, 3, 32'h1234, 1'b0);
        check_all("read3");

        // Write with zero-wait ack leaves MDR untouched
        mem_access(1'b1, 1, 32'hBEEF, 1'b0);
        mem_access(1'b0, 1, '0, 1'b0);
        check_all("write1");

        // Both strobes together are ignored
        MEM_RD = 1; MEM_WR = 1;
        @(negedge Clk);
        MEM_RD = 0; MEM_WR = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("both_strobes_req", W'(mem_req), 0);
        end

        // Read with no ack times out after T request cycles
        mem_access(1'b1, 0, '0, 1'b0);
        check_all("timeout");
        repeat (2) @(negedge Clk);
        check("timeout_sticky", W'(mem_timeout), 1);

        // Strobe during REQ is not queued
        mem_access(1'b1, 2, 32'hCAFE, 1'b1);
        repeat (4) @(negedge Clk);
        check_all("strobe_in_req");

        // Bus priority and conflict flag
        c = '0; c.ld_pc = 1; c.pcmux = 2'd0;
        dp_op(c, "pc_inc");
        c = '0; c.gate_pc = 1; c.gate_alu = 1; c.ld_mar = 1;
        dp_op(c, "conflict");
        check("conflict_mar", MAR_out, 32'h3001);
        check("conflict_flag", W'(bus_conflict), 1);
        dp_op('0, "conflict_clear");

        // 32-bit ADD overflow into the sign bit, then BRn / BRz
        load_ir(32'h0000_0200);
        mem_access(1'b1, 1, 32'h7FFF_FFFF, 1'b0);
        c = '0; c.gate_mdr = 1; c.ld_reg = 1;
        dp_op(c, "ld_r1");
        load_ir(32'h0000_1261);
        c = '0; c.gate_alu = 1; c.aluk = 2'd0; c.sr2mux = 1; c.ld_mar = 1; c.ld_cc = 1;
        dp_op(c, "add_imm");
        check("add_wrap", MAR_out, 32'h8000_0000);
        load_ir(32'h0000_127F);
        c = '0; c.gate_alu = 1; c.aluk = 2'd0; c.sr2mux = 1; c.ld_mar = 1;
        dp_op(c, "add_neg_imm");
        check("add_neg", MAR_out, 32'h7FFF_FFFE);
        load_ir(32'h0000_0800);
        c = '0; c.ld_ben = 1;
        dp_op(c, "brn");
        check("brn_ben", W'(BEN), 1);
        load_ir(32'h0000_0400);
        c = '0; c.ld_ben = 1;
        dp_op(c, "brz");
        check("brz_ben", W'(BEN), 0);

        // Randomised mix of datapath cycles, register loads and memory accesses
        for (int r = 0; r < 8; r++) begin
            load_ir(W'(r) << 9);
            mem_access(1'b1, 1, W'($urandom), 1'b0);
            c = '0; c.gate_mdr = 1; c.ld_reg = 1;
            dp_op(c, "rand_rf");
        end
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: mem_access(1'b1 ^ ($urandom_range(0, 3) == 0), $urandom_range(0, 5),
                              W'($urandom), $urandom_range(0, 7) == 0);
                1: load_ir(W'($urandom));
                default: begin
                    c = ctrl_t'(21'($urandom));
                    dp_op(c, "rand_op");
                end
            endcase
        end

        // Reset in the middle of an access drops mem_req asynchronously
        e.addr = m_mar; e.we = 0; e.wdata = m_mdr; e.len = T; e.mdr = '1; e.to = 1;
        exp_q.push_back(e);
        cur_lat = 0;
        MEM_RD = 1;
        @(negedge Clk);
        MEM_RD = 0;
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("async_rst_req", W'(mem_req), 0);
        check("async_rst_busy", W'(mem_busy), 0);
        model_reset();
        @(negedge Clk);
        check_all("mid_reset");
        check("mid_reset_timeout", W'(mem_timeout), 0);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("mid_reset_idle", W'(mem_req), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
